// File: rtl/fp_norm_round.sv
// Normalise-and-round stage behind the FP adder: normalises one bit per cycle,
// rounds to nearest-even and emits a packed single-precision result with {N,Z,C,V}.
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+3:0]       in_mant,
    input  logic                    in_sticky,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [3:0]              flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    logic          sign_r;
    logic [8:0]    e_r;
    logic [26:0]   m_r;
    logic          s_r;
    logic          zero_r;
    logic          sub_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [31:0]   result_r;
    logic [3:0]    flags_r;

    logic          lsb_s;
    logic          g_s;
    logic          r_s;
    logic          inexact_s;
    logic          up_s;
    logic [24:0]   sum_s;
    logic [9:0]    e_fin_s;
    logic [22:0]   frac_s;
    logic [30:0]   mag_s;
    logic          ovf_s;
    logic [31:0]   res_s;
    logic [3:0]    flg_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;

    // Round-to-nearest-even on the 24-bit significand m[25:2] and pack the result.
    always_comb begin
        lsb_s     = m_r[2];
        g_s       = m_r[1];
        r_s       = m_r[0];
        inexact_s = g_s | r_s | s_r;
        up_s      = g_s & (r_s | s_r | lsb_s);
        sum_s     = {1'b0, m_r[25:2]} + {24'd0, up_s};
        e_fin_s   = {1'b0, e_r} + {9'd0, sum_s[24]};
        frac_s    = sum_s[24] ? 23'd0 : sum_s[22:0];
        ovf_s     = 1'b0;
        mag_s     = 31'd0;
        if (zero_r) begin
            mag_s = 31'd0;
        end else if (sub_r) begin
            // A subnormal that rounds up into the hidden bit lands on exponent field 1.
            mag_s = {7'd0, sum_s[23], sum_s[22:0]};
        end else if (e_fin_s >= 10'd255) begin
            mag_s = {8'hFF, 23'd0};
            ovf_s = 1'b1;
        end else begin
            mag_s = {e_fin_s[7:0], frac_s};
        end
        res_s = {((mag_s == 31'd0) ? 1'b0 : sign_r), mag_s};
        flg_s = {res_s[31], (res_s[30:0] == 31'd0), inexact_s, ovf_s};
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            e_r         <= 9'd0;
            m_r         <= 27'd0;
            s_r         <= 1'b0;
            zero_r      <= 1'b0;
            sub_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= 32'd0;
            flags_r     <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r     <= in_sign;
                        e_r        <= (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
                        m_r        <= in_mant;
                        s_r        <= in_sticky;
                        zero_r     <= 1'b0;
                        sub_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                        state_r    <= NORM;
                    end
                end
                NORM: begin
                    if ((m_r == 27'd0) && !s_r) begin
                        zero_r  <= 1'b1;
                        state_r <= ROUND;
                    end else if (m_r[26]) begin
                        m_r <= {1'b0, m_r[26:1]};
                        s_r <= s_r | m_r[0];
                        e_r <= e_r + 9'd1;
                    end else if ((m_r[26:25] == 2'b00) && (e_r > 9'd1)) begin
                        m_r <= {m_r[25:0], 1'b0};
                        e_r <= e_r - 9'd1;
                    end else if (m_r[26:25] == 2'b00) begin
                        sub_r   <= 1'b1;
                        state_r <= ROUND;
                    end else begin
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    result_r    <= res_s;
                    flags_r     <= flg_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
